// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
// The master drives req; the arbiter drives everything else.
interface rr_arbiter8_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic       valid;
    logic [2:0] owner;
    logic       any_req;
    logic       preempt;

    modport master (
        output req,
        input  grant,
        input  valid,
        input  owner,
        input  any_req,
        input  preempt
    );

    modport slave (
        input  req,
        output grant,
        output valid,
        output owner,
        output any_req,
        output preempt
    );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with sticky grants and an optional hold limit that forces
// hand-over when other requesters are waiting.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned HOLD_W   = 5
) (
    input logic          clk,
    input logic          reset,
    rr_arbiter8_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    localparam logic [HOLD_W-1:0] HoldLast = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

    state_e            state_q, state_d;
    logic [7:0]        grant_q, grant_d;
    logic              valid_q, valid_d;
    logic [2:0]        owner_q, owner_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              preempt_q, preempt_d;

    logic [7:0] masked_req;
    logic       owner_req;
    logic       limit_hit;
    logic       release_now;
    logic [2:0] ptr_after;
    logic [3:0] idle_pick;
    logic [3:0] busy_pick;

    // Returns {found, index} of the first set bit scanning p, p+1, ... p+7 (mod 8).
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        // Scan from the far end so the nearest set bit is written last.
        for (int k = 7; k >= 0; k--) begin
            idx = p + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        masked_req  = bus.req & ~grant_q;
        owner_req   = bus.req[owner_q];
        limit_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HoldLast) && (masked_req != 8'h00);
        release_now = !owner_req || limit_hit;
        ptr_after   = owner_q + 3'd1;
        idle_pick   = pick(bus.req, ptr_q);
        busy_pick   = pick(masked_req, ptr_after);

        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        preempt_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (idle_pick[3]) begin
                    state_d    = StBusy;
                    grant_d    = 8'h01 << idle_pick[2:0];
                    owner_d    = idle_pick[2:0];
                    hold_cnt_d = '0;
                end
            end
            StBusy: begin
                if (release_now) begin
                    ptr_d = ptr_after;
                    if (busy_pick[3]) begin
                        grant_d    = 8'h01 << busy_pick[2:0];
                        owner_d    = busy_pick[2:0];
                        hold_cnt_d = '0;
                        // Only a forced hand-over counts; a voluntary drop is never a preempt.
                        preempt_d  = owner_req && limit_hit;
                    end else begin
                        grant_d = '0;
                        state_d = StIdle;
                    end
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase

        valid_d = |grant_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            valid_q    <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            valid_q    <= valid_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.valid   = valid_q;
    assign bus.owner   = owner_q;
    assign bus.preempt = preempt_q;
    assign bus.any_req = |bus.req;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: one instance with hold limit 4, one with the limit disabled, both
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_rr_arbiter8;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    rr_arbiter8_if if4 ();
    rr_arbiter8_if if0 ();

    rr_arbiter8 #(.MAX_HOLD(4), .HOLD_W(5)) u_arb4 (.clk(clk), .reset(reset), .bus(if4));
    rr_arbiter8 #(.MAX_HOLD(0), .HOLD_W(5)) u_arb0 (.clk(clk), .reset(reset), .bus(if0));

    typedef struct {
        bit         busy;
        int         owner;
        int         ptr;
        int         hold;
        logic [7:0] grant;
        bit         preempt;
    } model_t;

    model_t m4;
    model_t m0;
    int     n_checks;
    int     n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scan(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    function automatic model_t model_next(input model_t m, input logic rst,
                                          input logic [7:0] r, input int max_hold);
        model_t     n;
        int         w;
        logic [7:0] others;
        bit         mine;
        bit         limited;
        n = m;
        n.preempt = 0;
        if (rst) begin
            n.busy = 0; n.owner = 0; n.ptr = 0; n.hold = 0; n.grant = '0;
            return n;
        end
        if (!m.busy) begin
            w = scan(r, m.ptr);
            if (w >= 0) begin
                n.busy = 1; n.owner = w; n.hold = 0;
                n.grant = '0; n.grant[w] = 1'b1;
            end
        end else begin
            others = r;
            others[m.owner] = 1'b0;
            mine = r[m.owner];
            limited = (max_hold != 0) && (m.hold == max_hold - 1) && (others != 0);
            if (!mine || limited) begin
                n.ptr = (m.owner + 1) % 8;
                w = scan(others, n.ptr);
                if (w >= 0) begin
                    n.owner = w; n.hold = 0; n.preempt = mine;
                    n.grant = '0; n.grant[w] = 1'b1;
                end else begin
                    n.busy = 0; n.grant = '0;
                end
            end else if (m.hold < 31) begin
                n.hold = m.hold + 1;
            end
        end
        return n;
    endfunction

    // Drive one cycle of inputs, advance both models, and compare after the edge.
    task automatic step(input logic rst, input logic [7:0] r);
        @(negedge clk);
        reset = rst;
        if4.req = r;
        if0.req = r;
        #1;
        check_eq("any_req4", 32'(if4.any_req), 32'(|r));
        check_eq("any_req0", 32'(if0.any_req), 32'(|r));
        m4 = model_next(m4, rst, r, 4);
        m0 = model_next(m0, rst, r, 0);
        @(posedge clk);
        #1;
        check_eq("grant4", 32'(if4.grant), 32'(m4.grant));
        check_eq("valid4", 32'(if4.valid), 32'(m4.grant != 0));
        check_eq("owner4", 32'(if4.owner), 32'(m4.owner));
        check_eq("preempt4", 32'(if4.preempt), 32'(m4.preempt));
        check_eq("grant0", 32'(if0.grant), 32'(m0.grant));
        check_eq("valid0", 32'(if0.valid), 32'(m0.grant != 0));
        check_eq("owner0", 32'(if0.owner), 32'(m0.owner));
        check_eq("preempt0", 32'(if0.preempt), 32'(m0.preempt));
    endtask

    initial begin
        logic [7:0] r;
        int         sel;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if4.req  = '0;
        if0.req  = '0;

        // Reset with everything requesting, then full contention.
        step(1'b1, 8'hFF);
        check_eq("rst_grant", 32'(if4.grant), 32'h0);
        step(1'b1, 8'hFF);
        check_eq("rst_valid", 32'(if4.valid), 32'h0);
        step(1'b0, 8'hFF);
        check_eq("rst_release_grant", 32'(if4.grant), 32'h01);
        check_eq("first_no_preempt", 32'(if4.preempt), 32'h0);
        repeat (3) step(1'b0, 8'hFF);
        step(1'b0, 8'hFF);
        check_eq("contend_second", 32'(if4.grant), 32'h02);
        check_eq("contend_preempt", 32'(if4.preempt), 32'h1);
        repeat (40) step(1'b0, 8'hFF);

        // Single requester never gets preempted.
        step(1'b1, 8'h00);
        step(1'b0, 8'h20);
        check_eq("single_grant", 32'(if4.grant), 32'h20);
        check_eq("single_owner", 32'(if4.owner), 32'd5);
        repeat (20) begin
            step(1'b0, 8'h20);
            check_eq("single_hold", 32'(if4.grant), 32'h20);
            check_eq("single_nopre", 32'(if4.preempt), 32'h0);
        end
        step(1'b0, 8'h00);
        check_eq("single_drop_grant", 32'(if4.grant), 32'h0);
        check_eq("single_drop_valid", 32'(if4.valid), 32'h0);
        check_eq("idle_owner_kept", 32'(if4.owner), 32'd5);

        // No hold limit: back-to-back hand-over and wrap-around.
        step(1'b1, 8'h00);
        step(1'b0, 8'h81);
        check_eq("b2b_first", 32'(if0.grant), 32'h01);
        step(1'b0, 8'h80);
        check_eq("b2b_next", 32'(if0.grant), 32'h80);
        check_eq("b2b_nopre", 32'(if0.preempt), 32'h0);
        step(1'b0, 8'h01);
        check_eq("b2b_wrap", 32'(if0.grant), 32'h01);

        // Pointer fairness after a forced release from owner 2.
        step(1'b1, 8'h00);
        step(1'b0, 8'h04);
        repeat (4) step(1'b0, 8'h0C);
        check_eq("fair_next", 32'(if4.grant), 32'h08);
        check_eq("fair_preempt", 32'(if4.preempt), 32'h1);
        step(1'b0, 8'h04);
        check_eq("fair_back", 32'(if4.grant), 32'h04);

        // Reset in the middle of a grant.
        step(1'b1, 8'h00);
        repeat (3) step(1'b0, 8'h40);
        check_eq("mid_owner", 32'(if4.owner), 32'd6);
        step(1'b1, 8'h44);
        check_eq("mid_rst_grant", 32'(if4.grant), 32'h0);
        step(1'b0, 8'h44);
        check_eq("mid_after", 32'(if4.grant), 32'h04);
        repeat (6) step(1'b0, 8'h44);

        // Random traffic: mostly sticky requests with occasional bit flips and resets.
        r = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 2) begin
                step(1'b1, r);
            end else begin
                if (sel < 20) r[$urandom_range(0, 7)] ^= 1'b1;
                else if (sel < 25) r = 8'($urandom);
                else if (sel < 27) r = 8'h00;
                step(1'b0, r);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
